fft_r2_butterfly: RTL



---
 rtl/fft_r2_butterfly_if.sv | 48 ++++
 rtl/fft_r2_butterfly.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fft_r2_butterfly_if.sv
// Handshake and data bundle for the radix-2 butterfly.
// master drives operands and output ready; slave is the butterfly.
interface fft_r2_butterfly_if #(
    parameter int W     = 16,
    parameter int TW_W  = 16,
    parameter int TAG_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [W-1:0]     in_even_re;
    logic signed [W-1:0]     in_even_im;
    logic signed [W-1:0]     in_odd_re;
    logic signed [W-1:0]     in_odd_im;
    logic signed [TW_W-1:0]  tw_re;
    logic signed [TW_W-1:0]  tw_im;
    logic                    in_scale;
    logic                    in_inv;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [W-1:0]     out_x0_re;
    logic signed [W-1:0]     out_x0_im;
    logic signed [W-1:0]     out_x1_re;
    logic signed [W-1:0]     out_x1_im;
    logic [TAG_W-1:0]        out_tag;
    logic                    ovf_sticky;
    logic                    ovf_clr;

    modport master (
        output in_valid, in_even_re, in_even_im,
        output in_odd_re, in_odd_im, tw_re, tw_im,
        output in_scale, in_inv, in_tag,
        output out_ready, ovf_clr,
        input  in_ready, out_valid,
        input  out_x0_re, out_x0_im, out_x1_re, out_x1_im,
        input  out_tag, ovf_sticky
    );

    modport slave (
        input  in_valid, in_even_re, in_even_im,
        input  in_odd_re, in_odd_im, tw_re, tw_im,
        input  in_scale, in_inv, in_tag,
        input  out_ready, ovf_clr,
        output in_ready, out_valid,
        output out_x0_re, out_x0_im, out_x1_re, out_x1_im,
        output out_tag, ovf_sticky
    );
endinterface

// File: rtl/fft_r2_butterfly.sv
// Pipelined radix-2 DIT butterfly: X0 = E + W*O, X1 = E - W*O.
// Stages: multiply, round+add/sub, scale+saturate (output register).
module fft_r2_butterfly #(
    parameter int W     = 16,
    parameter int TW_W  = 16,
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_r2_butterfly_if.slave  bus
);
    localparam int PW  = W + TW_W;
    localparam int SW  = PW + 1;
    localparam int TWD = W + 2;
    localparam int XW  = W + 3;

    localparam logic signed [SW-1:0] HALF =
        {{(SW-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
    localparam logic signed [XW:0] ONE  = {{XW{1'b0}}, 1'b1};
    localparam logic signed [XW:0] MAXV =
        {{(XW-W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [XW:0] MINV =
        {{(XW-W+2){1'b1}}, {(W-1){1'b0}}};

    logic en, fire, rdy_q;

    // S1 state
    logic                   v1, sc1;
    logic [TAG_W-1:0]       tag1;
    logic signed [W-1:0]    e1_re, e1_im;
    logic signed [SW-1:0]   p1_re, p1_im;

    // S2 state
    logic                   v2, sc2;
    logic [TAG_W-1:0]       tag2;
    logic signed [XW-1:0]   x0_re2, x0_im2, x1_re2, x1_im2;

    // S3 / output state
    logic                   v3, ovf_q;
    logic [TAG_W-1:0]       tag3;
    logic signed [W-1:0]    o_x0_re, o_x0_im, o_x1_re, o_x1_im;

    logic signed [PW-1:0]   m_rr, m_ii, m_ir, m_ri;
    logic signed [SW-1:0]   p_re, p_im;
    logic signed [SW-1:0]   r_re, r_im;
    logic signed [TWD-1:0]  t_re, t_im;
    logic [W:0]             s_x0_re, s_x0_im, s_x1_re, s_x1_im;
    logic                   clamp;

    function automatic logic signed [XW:0] scl(
        input logic signed [XW-1:0] x,
        input logic                 s
    );
        logic signed [XW:0] xe;
        xe = (XW+1)'(x);
        return s ? ((xe + ONE) >>> 1) : xe;
    endfunction

    // Top bit flags a clamp, low W bits are the saturated value.
    function automatic logic [W:0] sat(input logic signed [XW:0] v);
        if (v > MAXV)
            return {1'b1, MAXV[W-1:0]};
        else if (v < MINV)
            return {1'b1, MINV[W-1:0]};
        else
            return {1'b0, v[W-1:0]};
    endfunction

    assign en   = !v3 || bus.out_ready;
    assign fire = bus.in_valid && bus.in_ready;

    assign bus.in_ready   = en && rdy_q;
    assign bus.out_valid  = v3;
    assign bus.out_x0_re  = o_x0_re;
    assign bus.out_x0_im  = o_x0_im;
    assign bus.out_x1_re  = o_x1_re;
    assign bus.out_x1_im  = o_x1_im;
    assign bus.out_tag    = tag3;
    assign bus.ovf_sticky = ovf_q;

    assign m_rr = PW'(bus.in_odd_re) * PW'(bus.tw_re);
    assign m_ii = PW'(bus.in_odd_im) * PW'(bus.tw_im);
    assign m_ir = PW'(bus.in_odd_im) * PW'(bus.tw_re);
    assign m_ri = PW'(bus.in_odd_re) * PW'(bus.tw_im);

    // Conjugate by choosing the sign of the cross terms at full width.
    assign p_re = bus.in_inv ? SW'(m_rr) + SW'(m_ii)
                             : SW'(m_rr) - SW'(m_ii);
    assign p_im = bus.in_inv ? SW'(m_ir) - SW'(m_ri)
                             : SW'(m_ir) + SW'(m_ri);

    assign r_re = (p1_re + HALF) >>> (TW_W - 1);
    assign r_im = (p1_im + HALF) >>> (TW_W - 1);
    assign t_re = r_re[TWD-1:0];
    assign t_im = r_im[TWD-1:0];

    assign s_x0_re = sat(scl(x0_re2, sc2));
    assign s_x0_im = sat(scl(x0_im2, sc2));
    assign s_x1_re = sat(scl(x1_re2, sc2));
    assign s_x1_im = sat(scl(x1_im2, sc2));
    assign clamp   = s_x0_re[W] | s_x0_im[W]
                   | s_x1_re[W] | s_x1_im[W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sc1   <= 1'b0;
            tag1  <= '0;
            e1_re <= '0;
            e1_im <= '0;
            p1_re <= '0;
            p1_im <= '0;
        end else if (en) begin
            v1    <= fire;
            sc1   <= bus.in_scale;
            tag1  <= bus.in_tag;
            e1_re <= bus.in_even_re;
            e1_im <= bus.in_even_im;
            p1_re <= p_re;
            p1_im <= p_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2     <= 1'b0;
            sc2    <= 1'b0;
            tag2   <= '0;
            x0_re2 <= '0;
            x0_im2 <= '0;
            x1_re2 <= '0;
            x1_im2 <= '0;
        end else if (en) begin
            v2     <= v1;
            sc2    <= sc1;
            tag2   <= tag1;
            x0_re2 <= XW'(e1_re) + XW'(t_re);
            x0_im2 <= XW'(e1_im) + XW'(t_im);
            x1_re2 <= XW'(e1_re) - XW'(t_re);
            x1_im2 <= XW'(e1_im) - XW'(t_im);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3      <= 1'b0;
            tag3    <= '0;
            o_x0_re <= '0;
            o_x0_im <= '0;
            o_x1_re <= '0;
            o_x1_im <= '0;
        end else if (en) begin
            v3 <= v2;
            if (v2) begin
                tag3    <= tag2;
                o_x0_re <= s_x0_re[W-1:0];
                o_x0_im <= s_x0_im[W-1:0];
                o_x1_re <= s_x1_re[W-1:0];
                o_x1_im <= s_x1_im[W-1:0];
            end
        end
    end

    // A new clamp beats a simultaneous clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en && v2 && clamp) begin
            ovf_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end
endmodule
